// File: rtl/ijtag_keyed_select_reg_pkg.sv
// ijtag_keyed_select_reg_pkg: shared state encodings for the keyed select register
package ijtag_keyed_select_reg_pkg;
  typedef enum logic [1:0] {
    ST_UNSEL  = 2'd0,
    ST_SEL    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;
endpackage

// File: rtl/ijtag_shift_reg.sv
// ijtag_shift_reg: capture/shift register, parallel load, serial tdi->tdo (LSB out), parallel out
//   tck, trst_n : clock, async active-low reset
//   en          : segment select, gates load and shift
//   load, pin   : parallel capture (priority over shift)
//   shift, tdi  : shift one bit toward tdo
//   tdo, sr     : serial out (sr[0]) and parallel contents
module ijtag_shift_reg #(
  parameter int W = 11
) (
  input  logic         tck,
  input  logic         trst_n,
  input  logic         en,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pin,
  input  logic         tdi,
  output logic         tdo,
  output logic [W-1:0] sr
);
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) sr <= '0;
    else if (en && load) sr <= pin;
    else if (en && shift) sr <= {tdi, sr[W-1:1]};
  assign tdo = sr[0];
endmodule

// File: rtl/ijtag_keyed_select_reg.sv
// ijtag_keyed_select_reg: key-protected IJTAG select register driving a segment select decoder
//   tck, trst_n                   : test clock, async active-low reset
//   select, capture_en, shift_en,
//   update_en, tdi, tdo           : IJTAG segment access (capture > shift > update)
//   sel_addr, sel_valid           : committed in-range address and its valid flag
//   fail_cnt, locked              : wrong-key count and permanent lock until trst_n
module ijtag_keyed_select_reg
  import ijtag_keyed_select_reg_pkg::*;
#(
  parameter int               SEL_W    = 3,
  parameter int               NUM_OUT  = 4,
  parameter int               KEY_W    = 8,
  parameter logic [KEY_W-1:0] KEY      = 8'hA5,
  parameter int               MAX_FAIL = 3
) (
  input  logic                            tck,
  input  logic                            trst_n,
  input  logic                            select,
  input  logic                            capture_en,
  input  logic                            shift_en,
  input  logic                            update_en,
  input  logic                            tdi,
  output logic                            tdo,
  output logic [SEL_W-1:0]                sel_addr,
  output logic                            sel_valid,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic                            locked
);
  localparam int W      = KEY_W + SEL_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  state_t state, nxt;
  logic [W-1:0] sr, pin;
  logic [FAIL_W-1:0] fail_nxt;
  logic key_ok, in_rng, act;
  ijtag_shift_reg #(.W(W)) u_sr (
    .tck(tck), .trst_n(trst_n), .en(select), .load(capture_en), .shift(shift_en),
    .pin(pin), .tdi(tdi), .tdo(tdo), .sr(sr)
  );
  // Capture image: {locked, zeros, fail_cnt, sel_addr}
  always_comb begin
    pin = '0;
    pin[SEL_W-1:0] = sel_addr;
    pin[SEL_W +: FAIL_W] = fail_cnt;
    pin[W-1] = locked;
  end
  assign key_ok   = sr[W-1:SEL_W] == KEY;
  assign in_rng   = {1'b0, sr[SEL_W-1:0]} < (SEL_W+1)'(NUM_OUT);
  assign act      = select && update_en && !capture_en && !shift_en && state != ST_LOCKED;
  assign fail_nxt = fail_cnt + 1'b1;
  always_comb begin
    nxt = state;
    nxt = !act ? state :
          key_ok ? (in_rng ? ST_SEL : ST_UNSEL) :
          fail_nxt == FAIL_W'(MAX_FAIL) ? ST_LOCKED : ST_UNSEL;
  end
  // fail_cnt cannot pass MAX_FAIL: reaching it locks the register and stops updates
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      state    <= ST_UNSEL;
      sel_addr <= '0;
      fail_cnt <= '0;
    end else begin
      state <= nxt;
      if (act && key_ok && in_rng) sel_addr <= sr[SEL_W-1:0];
      if (act) fail_cnt <= key_ok ? (in_rng ? '0 : fail_cnt) : fail_nxt;
    end
  assign sel_valid = state == ST_SEL;
  assign locked    = state == ST_LOCKED;
endmodule

// File: tb/tb_ijtag_keyed_select_reg.sv
// tb_ijtag_keyed_select_reg: directed bench with a behavioural model checked every cycle
module tb_ijtag_keyed_select_reg;
  logic tck = 1'b0;
  logic trst_n = 1'b1;
  logic select = 1'b0, capture_en = 1'b0, shift_en = 1'b0, update_en = 1'b0, tdi = 1'b0;
  logic tdo, sel_valid, locked;
  logic [2:0] sel_addr;
  logic [1:0] fail_cnt;
  int pass_n = 0, tot_n = 0;
  int m_sr = 0, m_addr = 0, m_valid = 0, m_fail = 0, m_lock = 0;

  ijtag_keyed_select_reg dut (
    .tck(tck), .trst_n(trst_n), .select(select), .capture_en(capture_en),
    .shift_en(shift_en), .update_en(update_en), .tdi(tdi), .tdo(tdo),
    .sel_addr(sel_addr), .sel_valid(sel_valid), .fail_cnt(fail_cnt), .locked(locked)
  );

  initial forever #5 tck = ~tck;

  task automatic chk(string nm, int got, int exp);
    tot_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Model: payload as an integer, key = sr/8, addr = sr%8, capture image built arithmetically
  always @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      m_sr <= 0; m_addr <= 0; m_valid <= 0; m_fail <= 0; m_lock <= 0;
    end else if (select) begin
      if (capture_en) m_sr <= m_lock * 1024 + m_fail * 8 + m_addr;
      else if (shift_en) m_sr <= m_sr / 2 + int'(tdi) * 1024;
      else if (update_en && m_lock == 0) begin
        if (m_sr / 8 == 165) begin
          if (m_sr % 8 < 4) begin m_addr <= m_sr % 8; m_valid <= 1; m_fail <= 0; end
          else m_valid <= 0;
        end else begin
          m_valid <= 0;
          m_fail <= m_fail + 1;
          if (m_fail + 1 == 3) m_lock <= 1;
        end
      end
    end

  always @(posedge tck) begin
    #2;
    chk("tdo", int'(tdo), m_sr % 2);
    chk("sel_addr", int'(sel_addr), m_addr);
    chk("sel_valid", int'(sel_valid), m_valid);
    chk("fail_cnt", int'(fail_cnt), m_fail);
    chk("locked", int'(locked), m_lock);
  end

  task automatic shift_in(input logic [10:0] p, input int n);
    shift_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = p[i];
      @(negedge tck);
    end
    shift_en = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic update();
    update_en = 1'b1;
    @(negedge tck);
    update_en = 1'b0;
  endtask

  task automatic lit(string nm, int a, int v, int f, int l);
    chk({nm, ".sel_addr"}, int'(sel_addr), a);
    chk({nm, ".sel_valid"}, int'(sel_valid), v);
    chk({nm, ".fail_cnt"}, int'(fail_cnt), f);
    chk({nm, ".locked"}, int'(locked), l);
  endtask

  task automatic pulse_reset();
    trst_n = 1'b0;
    #1;
    lit("async_reset", 0, 0, 0, 0);
    chk("async_reset.tdo", int'(tdo), 0);
    @(negedge tck);
    trst_n = 1'b1;
  endtask

  initial begin
    logic [10:0] exp_cap;
    trst_n = 1'b0;
    #1;
    lit("reset", 0, 0, 0, 0);
    chk("reset.tdo", int'(tdo), 0);
    repeat (2) @(negedge tck);
    trst_n = 1'b1;
    select = 1'b1;
    @(negedge tck);
    shift_in({8'hA5, 3'b010}, 11);
    update();
    lit("t1", 2, 1, 0, 0);
    capture_en = 1'b1;
    @(negedge tck);
    capture_en = 1'b0;
    exp_cap = 11'h002;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t2.tdo[%0d]", i), int'(tdo), int'(exp_cap[i]));
      shift_en = 1'b1;
      @(negedge tck);
    end
    shift_en = 1'b0;
    shift_in({8'hA5, 3'b110}, 11);
    update();
    lit("t3", 2, 0, 0, 0);
    shift_in(11'h000, 11);
    update();
    lit("t4.f1", 2, 0, 1, 0);
    update();
    lit("t4.f2", 2, 0, 2, 0);
    update();
    lit("t4.f3", 2, 0, 3, 1);
    shift_in({8'hA5, 3'b001}, 11);
    update();
    lit("t4.locked", 2, 0, 3, 1);
    pulse_reset();
    @(negedge tck);
    shift_in({8'hA5, 3'b001}, 5);
    pulse_reset();
    update();
    lit("t5", 0, 0, 1, 0);
    shift_in({8'hA5, 3'b011}, 11);
    update();
    lit("t6.pre", 3, 1, 0, 0);
    select = 1'b0;
    shift_in({8'hA5, 3'b001}, 11);
    update();
    capture_en = 1'b1;
    @(negedge tck);
    capture_en = 1'b0;
    lit("t6", 3, 1, 0, 0);
    chk("t6.tdo", int'(tdo), 1);
    repeat (2) @(negedge tck);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
